// File: rtl/alu_wb_pkg.sv
// Shared definitions for the execute/write-back sequencer: opcodes, FSM
// state encoding and instruction field positions.
package alu_wb_pkg;

  localparam int DW = 16;
  localparam int AW = 3;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_MOV  = 4'd7;
  localparam logic [3:0] OP_ADDI = 4'd8;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RW_HI  = 11;
  localparam int RW_LO  = 9;
  localparam int RA_HI  = 8;
  localparam int RA_LO  = 6;
  localparam int RB_HI  = 5;
  localparam int RB_LO  = 3;
  localparam int IMM_HI = 2;
  localparam int IMM_LO = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  // Opcodes above ADDI retire without writing and without touching flags.
  function automatic logic is_nop(input logic [3:0] op);
    return (op > OP_ADDI);
  endfunction

endpackage

// File: rtl/alu_wb_seq_alu16.sv
// Combinational 16-bit ALU; the carry output is the add carry-out or the
// subtract borrow, and zero for all other operations.
module alu16
  import alu_wb_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [3:0]    op,
  input  logic [2:0]    imm3,
  output logic [DW-1:0] result,
  output logic          carry
);

  logic [DW:0] wide_s;

  // Result is computed one bit wider so the top bit doubles as carry/borrow.
  always_comb begin
    wide_s = {(DW+1){1'b0}};
    case (op)
      OP_ADD:  wide_s = {1'b0, a} + {1'b0, b};
      OP_SUB:  wide_s = {(a < b), a - b};
      OP_AND:  wide_s = {1'b0, a & b};
      OP_OR:   wide_s = {1'b0, a | b};
      OP_XOR:  wide_s = {1'b0, a ^ b};
      OP_SLL:  wide_s = {1'b0, a << b[3:0]};
      OP_SRL:  wide_s = {1'b0, a >> b[3:0]};
      OP_MOV:  wide_s = {1'b0, a};
      OP_ADDI: wide_s = {1'b0, a} + {{(DW-2){1'b0}}, imm3};
      default: wide_s = {(DW+1){1'b0}};
    endcase
  end

  assign result = wide_s[DW-1:0];
  assign carry  = wide_s[DW];

endmodule

// File: rtl/alu_wb_seq.sv
// Four-state execute/write-back sequencer: reads two registers, runs the ALU
// and writes the result back through the register file write port.
module alu_wb_seq
  import alu_wb_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  input  logic [15:0]   instr,
  output logic          instr_ready,
  output logic [AW-1:0] RA,
  output logic [AW-1:0] RB,
  input  logic [DW-1:0] busA,
  input  logic [DW-1:0] busB,
  output logic [AW-1:0] RW,
  output logic [DW-1:0] busW,
  output logic          WE,
  output logic          done,
  output logic          flag_z,
  output logic          flag_c
);

  state_t          state_r;
  logic [3:0]      op_r;
  logic [AW-1:0]   rw_r;
  logic [2:0]      imm_r;
  logic [DW-1:0]   opa_r;
  logic [DW-1:0]   opb_r;
  logic            carry_r;
  logic            zero_r;
  logic [DW-1:0]   alu_res_s;
  logic            alu_carry_s;

  alu16 #(.DW(DW)) u_alu (
    .a      (opa_r),
    .b      (opb_r),
    .op     (op_r),
    .imm3   (imm_r),
    .result (alu_res_s),
    .carry  (alu_carry_s)
  );

  // Sequencer FSM; busW doubles as the latched result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      instr_ready <= 1'b1;
      op_r        <= 4'd0;
      rw_r        <= {AW{1'b0}};
      imm_r       <= 3'd0;
      opa_r       <= {DW{1'b0}};
      opb_r       <= {DW{1'b0}};
      carry_r     <= 1'b0;
      zero_r      <= 1'b0;
      RA          <= {AW{1'b0}};
      RB          <= {AW{1'b0}};
      RW          <= {AW{1'b0}};
      busW        <= {DW{1'b0}};
      WE          <= 1'b0;
      done        <= 1'b0;
      flag_z      <= 1'b0;
      flag_c      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (instr_valid && instr_ready) begin
            op_r        <= instr[OP_HI:OP_LO];
            rw_r        <= instr[RW_HI:RW_LO];
            imm_r       <= instr[IMM_HI:IMM_LO];
            RA          <= instr[RA_HI:RA_LO];
            RB          <= instr[RB_HI:RB_LO];
            instr_ready <= 1'b0;
            state_r     <= ST_READ;
          end else begin
            state_r     <= ST_IDLE;
          end
        end
        ST_READ: begin
          opa_r   <= busA;
          opb_r   <= busB;
          state_r <= ST_EXEC;
        end
        ST_EXEC: begin
          carry_r <= alu_carry_s;
          zero_r  <= (alu_res_s == {DW{1'b0}});
          busW    <= alu_res_s;
          RW      <= rw_r;
          WE      <= !is_nop(op_r);
          done    <= 1'b1;
          state_r <= ST_WRITE;
        end
        ST_WRITE: begin
          WE          <= 1'b0;
          done        <= 1'b0;
          instr_ready <= 1'b1;
          if (!is_nop(op_r)) begin
            flag_z <= zero_r;
            flag_c <= carry_r;
          end
          state_r     <= ST_IDLE;
        end
        default: begin
          WE          <= 1'b0;
          done        <= 1'b0;
          instr_ready <= 1'b1;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_wb_seq.md
# alu_wb_seq

Multi-cycle execute/write-back sequencer directly downstream of the 8×16 register file (`reg_file`). It accepts one 16-bit register-register instruction over a valid/ready handshake. It drives the register file read addresses, captures `busA`/`busB`, and computes a 16-bit ALU result. It then writes the result back through the `RW`/`busW`/`WE` write port, so it both consumes and feeds the register file.

## Interface
- `DW`, 16, datapath width (must match `reg_file` bus width)
- `AW`, 3, register address width (8 registers)
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `instr_valid`  in  1  instruction present on `instr`
- `instr`  in  16  `[15:12]` op, `[11:9]` rw, `[8:6]` ra, `[5:3]` rb, `[2:0]` imm3
- `instr_ready`  out  1  high only in IDLE; transfer when valid&&ready at posedge
- `RA`, `RB`  out  AW  register file read addresses
- `busA`, `busB`  in  DW  register file read data (combinational from `RA`/`RB`)
- `RW`  out  AW  write address
- `busW`  out  DW  write data
- `WE`  out  1  write enable; register file writes at posedge when high
- `done`  out  1  one-cycle pulse when an instruction retires
- `flag_z`, `flag_c`  out  1  zero / carry-borrow flags of last writing op

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL (busA << busB[3:0]), 6 SRL (logical), 7 MOV (busA), 8 ADDI (busA + zero-extended imm3). Opcodes 9–15 are NOP.
- FSM states: IDLE → READ → EXEC → WRITE → IDLE. No other transitions except reset.
  - IDLE: `instr_ready`=1. On handshake, latch `instr` into an internal register, then go to READ.
  - READ: `RA`/`RB` driven from the latched instruction. `busA`/`busB` captured into operand registers at the end of the cycle.
  - EXEC: ALU computes from the operand registers. Result, carry and zero are latched into result registers.
  - WRITE: `RW`=latched rw and `busW`=result. `WE`=1 unless the op is NOP. `done`=1. Flags update at the end of WRITE for non-NOP ops only.
- Arithmetic: all results truncated to 16 bits (wrap).
  - ADD/ADDI: `flag_c` = bit 16 of the 17-bit sum.
  - SUB: `flag_c`=1 iff busA < busB (unsigned borrow).
  - Logic, shift and MOV ops: `flag_c`=0.
  - `flag_z`=1 iff the 16-bit result is 0000.
- Shifts: amount 0 passes busA unchanged; amount 15 is a legal shift.
- Write to any register, including R0, is permitted. `rw` equal to `ra`/`rb` is legal, because operands are already captured before WRITE.
- `instr` is don't-care outside IDLE. `instr_valid` held high across retirement starts the next instruction on the cycle after WRITE.

## Timing
- Reset values (async, immediate): state=IDLE, `instr_ready`=1, `WE`=0, `done`=0, `RA`=`RB`=`RW`=0, `busW`=0000, flags 0, internal registers 0.
- Handshake at posedge k: READ in cycle k..k+1, EXEC k+1..k+2, WRITE k+2..k+3. The register file commits at posedge k+3.
- Latency is 3 cycles from acceptance to commit. Throughput is one instruction per 4 cycles; `instr_ready` is low for exactly 3 cycles per instruction.
- `WE` and `done` are high for exactly one cycle, never outside WRITE.
- Reset asserted mid-operation (any state): `WE` drops asynchronously, so no partial or duplicate write occurs. The in-flight instruction is discarded and not retried.
- Reset release takes effect at the next posedge. The sequencer is ready in the first cycle after release.

## Structure
- Shared package `alu_wb_pkg` holds the opcode localparams, the FSM state encoding (2-bit) and instruction field bit positions. The bench uses the same package.
- One combinational sub-module, `alu16`: inputs a, b, op, imm3; outputs result[15:0] and carry. The FSM, latches and flag registers stay in `alu_wb_seq`.

## Test plan
- Preload R0=ff00 and R1=00ff. Then issue ADD rw=2, ra=0, rb=1. Required: R2=ffff at posedge k+3, `flag_z`=0, `flag_c`=0, and `done` pulses once.
- Preload R3=ffff and R4=0001. Then issue ADD rw=5, ra=3, rb=4. Required: R5=0000, `flag_z`=1, `flag_c`=1.
- Preload R0=0005 and R1=0007. Then issue SUB rw=0, ra=0, rb=1. Required: R0=fffe, `flag_c`=1. Then issue SLL rw=6, ra=0, rb=1 with R1=0004. Required: R6=ffe0.
- Issue opcode 12. Required: `WE` stays 0 through all four cycles, `done` pulses, all registers and flags are unchanged.
- Drop `rst_n` during EXEC of ADD rw=7. Required: `WE` is never 1, R7 is unchanged, and `instr_ready`=1 in the first cycle after release.
- Hold `instr_valid`=1 with three ADDI instructions (imm3=1 onto R2). Required: an acceptance every 4 cycles and R2 incremented by exactly 3.
